// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_slave
// Description : AXI4-Lite slave with a four-word register map:
//                 0x00 REG0   RW
//                 0x04 REG1   RW
//                 0x08 SUM    RO  (REG0 + REG1, modulo 2^32)
//                 0x0C WCOUNT RO  (number of committed OKAY writes, wraps)
//               The write and read paths are independent state machines.
//               Every output comes straight from a flop.
// Ports       : s_axi_aclk / s_axi_areset - clock, synchronous active-high reset
//               AW, W, B channels          - write address / data / response
//               AR, R channels             - read address / data
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int                    c_STRB_W        = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] c_RESP_OKAY     = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] c_RESP_SLVERR   = RESP_WIDTH'(2);
    localparam logic [RESP_WIDTH-1:0] c_RESP_DECERR   = RESP_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR     = ADDR_WIDTH'(12);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Top strobe bit exists on the port but carries no byte lane.
    logic w_unused_strb_msb;
    assign w_unused_strb_msb = s_axi_wstrb[c_STRB_W];

    // Alignment is checked before range, so 0x0E reports SLVERR, not DECERR.
    function automatic logic [RESP_WIDTH-1:0] f_decode(input logic [ADDR_WIDTH-1:0] addr);
        if (addr[1:0] != 2'b00)      return c_RESP_SLVERR;
        else if (addr > c_LAST_ADDR) return c_RESP_DECERR;
        else                         return c_RESP_OKAY;
    endfunction

    // Register state
    logic [DATA_WIDTH-1:0] r_reg0_q,   w_reg0_d;
    logic [DATA_WIDTH-1:0] r_reg1_q,   w_reg1_d;
    logic [DATA_WIDTH-1:0] r_wcount_q, w_wcount_d;
    logic [DATA_WIDTH-1:0] w_sum;

    // Write path state
    logic [0:0]            r_wstate_q,  w_wstate_d;
    logic                  r_awready_q, w_awready_d;
    logic                  r_wready_q,  w_wready_d;
    logic                  r_aw_got_q,  w_aw_got_d;
    logic                  r_w_got_q,   w_w_got_d;
    logic [ADDR_WIDTH-1:0] r_awaddr_q,  w_awaddr_d;
    logic [DATA_WIDTH-1:0] r_wdata_q,   w_wdata_d;
    logic [c_STRB_W-1:0]   r_wstrb_q,   w_wstrb_d;
    logic                  r_bvalid_q,  w_bvalid_d;
    logic [RESP_WIDTH-1:0] r_bresp_q,   w_bresp_d;

    // Read path state
    logic [0:0]            r_rstate_q,  w_rstate_d;
    logic                  r_arready_q, w_arready_d;
    logic                  r_rvalid_q,  w_rvalid_d;
    logic [DATA_WIDTH-1:0] r_rdata_q,   w_rdata_d;
    logic [RESP_WIDTH-1:0] r_rresp_q,   w_rresp_d;

    // Write helpers
    logic                  w_aw_hs, w_w_hs, w_aw_have, w_w_have;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data, w_wr_base, w_wr_merged;
    logic [c_STRB_W-1:0]   w_wr_strb;
    logic [RESP_WIDTH-1:0] w_wr_resp;

    // Read helpers
    logic [RESP_WIDTH-1:0] w_rd_resp;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_sum = r_reg0_q + r_reg1_q;

    // ------------------------------------------------------------------
    // Write path. A beat arriving this cycle is used directly so that the
    // commit lands on the same edge that latches the second beat.
    // ------------------------------------------------------------------
    always_comb begin
        w_wstate_d  = r_wstate_q;
        w_awready_d = r_awready_q;
        w_wready_d  = r_wready_q;
        w_aw_got_d  = r_aw_got_q;
        w_w_got_d   = r_w_got_q;
        w_awaddr_d  = r_awaddr_q;
        w_wdata_d   = r_wdata_q;
        w_wstrb_d   = r_wstrb_q;
        w_bvalid_d  = r_bvalid_q;
        w_bresp_d   = r_bresp_q;
        w_reg0_d    = r_reg0_q;
        w_reg1_d    = r_reg1_q;
        w_wcount_d  = r_wcount_q;

        w_aw_hs   = r_awready_q & s_axi_awvalid;
        w_w_hs    = r_wready_q  & s_axi_wvalid;
        w_aw_have = w_aw_hs | r_aw_got_q;
        w_w_have  = w_w_hs  | r_w_got_q;

        w_wr_addr = r_aw_got_q ? r_awaddr_q : s_axi_awaddr;
        w_wr_data = r_w_got_q  ? r_wdata_q  : s_axi_wdata;
        w_wr_strb = r_w_got_q  ? r_wstrb_q  : s_axi_wstrb[c_STRB_W-1:0];

        // The read-only words decode fine but reject writes.
        w_wr_resp = f_decode(w_wr_addr);
        if (w_wr_resp == c_RESP_OKAY && w_wr_addr[3])
            w_wr_resp = c_RESP_SLVERR;

        w_wr_base   = w_wr_addr[2] ? r_reg1_q : r_reg0_q;
        w_wr_merged = w_wr_base;
        for (int i = 0; i < c_STRB_W; i++) begin
            if (w_wr_strb[i])
                w_wr_merged[8*i +: 8] = w_wr_data[8*i +: 8];
        end

        case (r_wstate_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_awaddr_d = s_axi_awaddr;
                    w_aw_got_d = 1'b1;
                end
                if (w_w_hs) begin
                    w_wdata_d = s_axi_wdata;
                    w_wstrb_d = s_axi_wstrb[c_STRB_W-1:0];
                    w_w_got_d = 1'b1;
                end
                // Also raises the readies on the first edge after reset.
                w_awready_d = ~w_aw_have;
                w_wready_d  = ~w_w_have;

                if (w_aw_have && w_w_have) begin
                    if (w_wr_resp == c_RESP_OKAY) begin
                        if (w_wr_addr[2]) w_reg1_d = w_wr_merged;
                        else              w_reg0_d = w_wr_merged;
                        w_wcount_d = r_wcount_q + DATA_WIDTH'(1);
                    end
                    w_aw_got_d  = 1'b0;
                    w_w_got_d   = 1'b0;
                    w_awready_d = 1'b0;
                    w_wready_d  = 1'b0;
                    w_bvalid_d  = 1'b1;
                    w_bresp_d   = w_wr_resp;
                    w_wstate_d  = W_RESP;
                end
            end
            default: begin
                if (s_axi_bready) begin
                    w_bvalid_d  = 1'b0;
                    w_awready_d = 1'b1;
                    w_wready_d  = 1'b1;
                    w_wstate_d  = W_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read path. Register values are sampled before any same-edge write
    // lands, so a coincident read returns the pre-write contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_rstate_d  = r_rstate_q;
        w_arready_d = r_arready_q;
        w_rvalid_d  = r_rvalid_q;
        w_rdata_d   = r_rdata_q;
        w_rresp_d   = r_rresp_q;

        w_rd_resp = f_decode(s_axi_araddr);
        case (s_axi_araddr[3:2])
            2'd0:    w_rd_val = r_reg0_q;
            2'd1:    w_rd_val = r_reg1_q;
            2'd2:    w_rd_val = w_sum;
            default: w_rd_val = r_wcount_q;
        endcase

        case (r_rstate_q)
            R_IDLE: begin
                w_arready_d = 1'b1;
                if (r_arready_q && s_axi_arvalid) begin
                    w_rdata_d   = (w_rd_resp == c_RESP_OKAY) ? w_rd_val : '0;
                    w_rresp_d   = w_rd_resp;
                    w_rvalid_d  = 1'b1;
                    w_arready_d = 1'b0;
                    w_rstate_d  = R_DATA;
                end
            end
            default: begin
                if (s_axi_rready) begin
                    w_rvalid_d  = 1'b0;
                    w_arready_d = 1'b1;
                    w_rstate_d  = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_reg0_q    <= '0;
            r_reg1_q    <= '0;
            r_wcount_q  <= '0;
            r_wstate_q  <= W_IDLE;
            r_awready_q <= 1'b0;
            r_wready_q  <= 1'b0;
            r_aw_got_q  <= 1'b0;
            r_w_got_q   <= 1'b0;
            r_awaddr_q  <= '0;
            r_wdata_q   <= '0;
            r_wstrb_q   <= '0;
            r_bvalid_q  <= 1'b0;
            r_bresp_q   <= '0;
            r_rstate_q  <= R_IDLE;
            r_arready_q <= 1'b0;
            r_rvalid_q  <= 1'b0;
            r_rdata_q   <= '0;
            r_rresp_q   <= '0;
        end else begin
            r_reg0_q    <= w_reg0_d;
            r_reg1_q    <= w_reg1_d;
            r_wcount_q  <= w_wcount_d;
            r_wstate_q  <= w_wstate_d;
            r_awready_q <= w_awready_d;
            r_wready_q  <= w_wready_d;
            r_aw_got_q  <= w_aw_got_d;
            r_w_got_q   <= w_w_got_d;
            r_awaddr_q  <= w_awaddr_d;
            r_wdata_q   <= w_wdata_d;
            r_wstrb_q   <= w_wstrb_d;
            r_bvalid_q  <= w_bvalid_d;
            r_bresp_q   <= w_bresp_d;
            r_rstate_q  <= w_rstate_d;
            r_arready_q <= w_arready_d;
            r_rvalid_q  <= w_rvalid_d;
            r_rdata_q   <= w_rdata_d;
            r_rresp_q   <= w_rresp_d;
        end
    end

    assign s_axi_awready = r_awready_q;
    assign s_axi_wready  = r_wready_q;
    assign s_axi_bvalid  = r_bvalid_q;
    assign s_axi_bresp   = r_bresp_q;
    assign s_axi_arready = r_arready_q;
    assign s_axi_rvalid  = r_rvalid_q;
    assign s_axi_rdata   = r_rdata_q;
    assign s_axi_rresp   = r_rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_reg_slave
// Description : Directed self-checking bench for axi_lite_reg_slave. Inputs
//               change on the falling edge; outputs are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_slave;

    logic        clk = 1'b0;
    logic        s_axi_areset = 1'b1;
    logic [7:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [4:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [2:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [2:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [2:0]  resp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axi_lite_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESP_WIDTH (3)
    ) u_dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (s_axi_areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Full write: both beats offered together, each dropped once accepted.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [4:0] strb, output logic [2:0] bresp);
        bit aw_acc, w_acc;
        int n;
        s_axi_awaddr = addr;
        s_axi_wdata = data;
        s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        n = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
            aw_acc = s_axi_awvalid && s_axi_awready;
            w_acc = s_axi_wvalid && s_axi_wready;
            @(negedge clk);
            n++;
            if (aw_acc) s_axi_awvalid = 1'b0;
            if (w_acc) s_axi_wvalid = 1'b0;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_bvalid_seen", {31'b0, s_axi_bvalid}, 32'd1);
        bresp = s_axi_bresp;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [2:0] rresp);
        bit ar_acc;
        int n;
        s_axi_araddr = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arvalid && n < 20) begin
            ar_acc = s_axi_arready;
            @(negedge clk);
            n++;
            if (ar_acc) s_axi_arvalid = 1'b0;
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_rvalid_seen", {31'b0, s_axi_rvalid}, 32'd1);
        data = s_axi_rdata;
        rresp = s_axi_rresp;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_awready", {31'b0, s_axi_awready}, 32'd0);
        check("rst_wready",  {31'b0, s_axi_wready},  32'd0);
        check("rst_arready", {31'b0, s_axi_arready}, 32'd0);
        check("rst_bvalid",  {31'b0, s_axi_bvalid},  32'd0);
        check("rst_rvalid",  {31'b0, s_axi_rvalid},  32'd0);
        check("rst_rdata",   s_axi_rdata, 32'd0);
        s_axi_areset = 1'b0;
        @(negedge clk);
        check("post_rst_awready", {31'b0, s_axi_awready}, 32'd1);
        check("post_rst_wready",  {31'b0, s_axi_wready},  32'd1);
        check("post_rst_arready", {31'b0, s_axi_arready}, 32'd1);

        // ---------------- AW and W in the same cycle ----------------
        s_axi_awaddr = 8'h00;
        s_axi_wdata = 32'hDEADBEEF;
        s_axi_wstrb = 5'h0F;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        check("same_cyc_bvalid",  {31'b0, s_axi_bvalid},  32'd1);
        check("same_cyc_bresp",   {29'b0, s_axi_bresp},   32'd0);
        check("same_cyc_awready", {31'b0, s_axi_awready}, 32'd0);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("b_done_bvalid",  {31'b0, s_axi_bvalid},  32'd0);
        check("b_done_awready", {31'b0, s_axi_awready}, 32'd1);
        axi_read(8'h00, rdata, resp);
        check("reg0_deadbeef", rdata, 32'hDEADBEEF);
        check("reg0_rresp", {29'b0, resp}, 32'd0);
        axi_read(8'h0C, rdata, resp);
        check("wcount_1", rdata, 32'd1);

        // ---------------- W two cycles ahead of AW ----------------
        axi_write(8'h04, 32'hAABBCCDD, 5'h0F, resp);
        s_axi_wdata = 32'h00000012;
        s_axi_wstrb = 5'h01;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check("w_first_wready", {31'b0, s_axi_wready}, 32'd0);
        check("w_first_bvalid0", {31'b0, s_axi_bvalid}, 32'd0);
        @(negedge clk);
        check("w_first_bvalid1", {31'b0, s_axi_bvalid}, 32'd0);
        s_axi_awaddr = 8'h04;
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check("aw_late_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        check("aw_late_bresp",  {29'b0, s_axi_bresp},  32'd0);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        axi_read(8'h04, rdata, resp);
        check("reg1_byte0", rdata, 32'hAABBCC12);

        // ---------------- SUM wraps, RO write rejected ----------------
        axi_write(8'h00, 32'hFFFFFFFF, 5'h0F, resp);
        axi_write(8'h04, 32'h00000002, 5'h0F, resp);
        axi_read(8'h08, rdata, resp);
        check("sum_wrap", rdata, 32'h00000001);
        check("sum_rresp", {29'b0, resp}, 32'd0);
        axi_write(8'h08, 32'h12345678, 5'h0F, resp);
        check("wr_sum_slverr", {29'b0, resp}, 32'd2);
        axi_write(8'h0C, 32'h12345678, 5'h0F, resp);
        check("wr_wcount_slverr", {29'b0, resp}, 32'd2);
        axi_read(8'h0C, rdata, resp);
        check("wcount_5", rdata, 32'd5);

        // ---------------- decode errors ----------------
        axi_read(8'h10, rdata, resp);
        check("rd_decerr_resp", {29'b0, resp}, 32'd3);
        check("rd_decerr_data", rdata, 32'd0);
        axi_read(8'h05, rdata, resp);
        check("rd_unaligned_resp", {29'b0, resp}, 32'd2);
        check("rd_unaligned_data", rdata, 32'd0);
        axi_write(8'h10, 32'h1, 5'h0F, resp);
        check("wr_decerr_resp", {29'b0, resp}, 32'd3);

        // Unaligned write with bready held low: response must sit still.
        s_axi_awaddr = 8'h06;
        s_axi_wdata = 32'h0000FFFF;
        s_axi_wstrb = 5'h0F;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid",  {31'b0, s_axi_bvalid},  32'd1);
            check("stall_bresp",   {29'b0, s_axi_bresp},   32'd2);
            check("stall_awready", {31'b0, s_axi_awready}, 32'd0);
            check("stall_wready",  {31'b0, s_axi_wready},  32'd0);
            @(negedge clk);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        axi_read(8'h04, rdata, resp);
        check("reg1_after_errs", rdata, 32'h00000002);
        axi_read(8'h0C, rdata, resp);
        check("wcount_after_errs", rdata, 32'd5);

        // ---------------- read and write on the same edge ----------------
        axi_write(8'h00, 32'h00000001, 5'h0F, resp);
        s_axi_awaddr = 8'h00;
        s_axi_wdata = 32'h00000005;
        s_axi_wstrb = 5'h0F;
        s_axi_araddr = 8'h00;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        check("coinc_rvalid", {31'b0, s_axi_rvalid}, 32'd1);
        check("coinc_rdata_old", s_axi_rdata, 32'h00000001);
        check("coinc_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        s_axi_rready = 1'b1;
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
        axi_read(8'h00, rdata, resp);
        check("coinc_rdata_new", rdata, 32'h00000005);

        // ---------------- byte strobes ----------------
        // Only the ignored top strobe bit set: OKAY, no data change, counted.
        axi_write(8'h04, 32'hFFFFFFFF, 5'h10, resp);
        check("strb0_resp", {29'b0, resp}, 32'd0);
        axi_read(8'h04, rdata, resp);
        check("strb0_reg1", rdata, 32'h00000002);
        axi_write(8'h00, 32'h12345678, 5'h0C, resp);
        axi_read(8'h00, rdata, resp);
        check("strb_upper", rdata, 32'h12340005);
        axi_read(8'h08, rdata, resp);
        check("sum_after_strb", rdata, 32'h12340007);
        axi_read(8'h0C, rdata, resp);
        check("wcount_9", rdata, 32'd9);

        // ---------------- reset while a response is pending ----------------
        s_axi_awaddr = 8'h00;
        s_axi_wdata = 32'hCAFE0000;
        s_axi_wstrb = 5'h0F;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        check("pre_rst_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        s_axi_areset = 1'b1;
        @(negedge clk);
        check("mid_rst_bvalid",  {31'b0, s_axi_bvalid},  32'd0);
        check("mid_rst_awready", {31'b0, s_axi_awready}, 32'd0);
        s_axi_areset = 1'b0;
        @(negedge clk);
        check("rel_awready", {31'b0, s_axi_awready}, 32'd1);
        check("rel_wready",  {31'b0, s_axi_wready},  32'd1);
        check("rel_arready", {31'b0, s_axi_arready}, 32'd1);
        check("rel_bvalid",  {31'b0, s_axi_bvalid},  32'd0);
        axi_read(8'h00, rdata, resp);
        check("rel_reg0", rdata, 32'd0);
        axi_read(8'h0C, rdata, resp);
        check("rel_wcount", rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 3, meaning response width; codes zero-extended: OKAY=0, SLVERR=2, DECERR=3.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 s_axi_aclk  in  1  clock; all logic on rising edge.
REQ-006 s_axi_areset  in  1  synchronous active-high reset.
REQ-007 s_axi_awaddr in ADDR_WIDTH; s_axi_awvalid in 1; s_axi_awready out 1 -- write address channel.
REQ-008 s_axi_wdata in DATA_WIDTH; s_axi_wstrb in DATA_WIDTH/8+1 (MSB ignored); s_axi_wvalid in 1; s_axi_wready out 1 -- write data channel.
REQ-009 s_axi_bresp out RESP_WIDTH; s_axi_bvalid out 1; s_axi_bready in 1 -- write response channel.
REQ-010 s_axi_araddr in ADDR_WIDTH; s_axi_arvalid in 1; s_axi_arready out 1 -- read address channel.
REQ-011 s_axi_rdata out DATA_WIDTH; s_axi_rresp out RESP_WIDTH; s_axi_rvalid out 1; s_axi_rready in 1 -- read data channel.

Function
REQ-012 Register map SHALL be: 0x00 REG0 RW; 0x04 REG1 RW; 0x08 SUM RO = (REG0+REG1) mod 2^32; 0x0C WCOUNT RO = committed OKAY writes, wraps 0xFFFFFFFF->0.
REQ-013 Address decode, read or write: addr[1:0]!=0 -> SLVERR; aligned addr >0x0C -> DECERR; no register effect on any error.
REQ-014 Write to 0x08 or 0x0C SHALL return SLVERR, no state change, WCOUNT not incremented.
REQ-015 Write FSM states: W_IDLE, W_RESP.
REQ-016 W_IDLE: awready and wready each SHALL be 1; AW and W handshakes SHALL be accepted independently in any order or the same cycle; on its handshake, each ready drops to 0 next cycle and the beat is latched.
REQ-017 At the edge where the second of AW/W is latched (or both together), the write SHALL commit, bvalid=1 and bresp set from the following cycle; FSM -> W_RESP.
REQ-018 Commit: byte lane i of target register updated only when wstrb[i]=1; wstrb[3:0]=0 with valid address -> OKAY, no data change, WCOUNT still increments.
REQ-019 W_RESP: bvalid, bresp held stable, awready=wready=0 until bvalid&bready; on that edge bvalid->0, awready=wready->1, FSM -> W_IDLE.
REQ-020 Read FSM states: R_IDLE, R_DATA.
REQ-021 R_IDLE: arready=1; on arvalid&arready edge, rdata/rresp registered from decode, rvalid=1 and arready=0 next cycle; FSM -> R_DATA. Error reads return rdata=0.
REQ-022 R_DATA: rvalid, rdata, rresp held stable until rvalid&rready; on that edge rvalid->0, arready->1, FSM -> R_IDLE.
REQ-023 Maximum throughput SHALL be one read per 2 cycles and one write per 2 cycles; read and write FSMs SHALL operate concurrently and independently.
REQ-024 Read and write commit at the same edge to the same or dependent register: read SHALL return the pre-write value (REG0/REG1/SUM/WCOUNT).
REQ-025 No output SHALL depend combinationally on any input.

Reset
REQ-026 While s_axi_areset=1 at an edge: REG0=REG1=WCOUNT=0; awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; FSMs -> W_IDLE/R_IDLE.
REQ-027 First edge with reset low SHALL set awready=wready=arready=1.
REQ-028 Reset mid-transaction SHALL abandon it: latched AW/W and pending B/R discarded, no partial register update.

Verification
REQ-029 AW 0x00 and W 0xDEADBEEF strb 0xF same cycle -> bvalid next cycle, bresp=0; read 0x00 -> 0xDEADBEEF, WCOUNT read=1.
REQ-030 W (0x00000012, strb 0x1) two cycles before AW 0x04 with REG1=0xAABBCCDD -> REG1=0xAABBCC12; bvalid only after AW accepted.
REQ-031 REG0=0xFFFFFFFF, REG1=2 -> read 0x08 returns 0x00000001, rresp=0; write 0x08 -> bresp=2, WCOUNT unchanged.
REQ-032 Read 0x10 -> rresp=3, rdata=0; write 0x06 -> bresp=2; bready held low 5 cycles -> bvalid, bresp stable, awready=0 throughout.
REQ-033 Write 0x00=5 committing same edge as read 0x00 (REG0 previously 1) -> rdata=1; next read -> 5.
REQ-034 Assert reset while bvalid=1 waiting for bready -> bvalid=0, REG0=0, WCOUNT=0 after reset; readies 1 one cycle after release.
